// File: rtl/vram_cpu_if.sv
// CPU-side access port of the framebuffer arbiter: one request/acknowledge
// transaction per access, carrying an RGB332 byte in either direction.
interface vram_cpu_if #(
  parameter int ADDR_WIDTH = 17
);
  // cpu_req is the valid: the master raises it with cpu_we/cpu_addr/cpu_wdata
  // and holds all four stable until the one-cycle cpu_ack, which doubles as
  // ready and marks cpu_rdata valid. cpu_req still high in the cycle after
  // cpu_ack starts a new transaction; dropping it before cpu_ack cancels.
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [7:0]            cpu_wdata;
  logic                  cpu_ack;
  logic [7:0]            cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one synchronous-read framebuffer RAM between HDMI scan-out (strict
// priority, fixed 2-cycle x/y-to-rgb latency) and a CPU req/ack requester.
module vram_arbiter #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int ADDR_WIDTH  = 17,
  parameter int PIX_LATENCY = 2
) (
  input  logic                  clock25,
  input  logic                  reset,
  input  logic [11:0]           vid_x,
  input  logic [11:0]           vid_y,
  output logic [7:0]            vid_r,
  output logic [7:0]            vid_g,
  output logic [7:0]            vid_b,
  vram_cpu_if.slave             cpu,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic                  dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [0:0]             r_state;
  logic                   r_vld;
  logic [11:0]            r_x;
  logic [11:0]            r_y;
  logic                   r_black;
  logic [PIX_LATENCY-2:0] r_vpend;
  logic                   r_rd_ok;

  logic w_slot;
  logic w_vin;
  logic w_cin;
  logic w_issue;

  function automatic logic [23:0] rgb332(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6],
            p[4:2], p[4:2], p[4:3],
            p[1:0], p[1:0], p[1:0], p[1:0]};
  endfunction

  always_comb begin
    w_slot  = !r_vld || (vid_x != r_x) || (vid_y != r_y);
    w_vin   = (32'(vid_x) < 32'(WIDTH)) && (32'(vid_y) < 32'(HEIGHT));
    w_cin   = 32'(cpu.cpu_addr) < 32'(WIDTH * HEIGHT);
    w_issue = (r_state == S_IDLE) && cpu.cpu_req && !w_slot && !reset;
  end

  // The product is formed at full width; truncation happens only after the
  // range check so an out-of-range pixel never aliases onto a real address.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (!reset) begin
      if (w_issue) begin
        ram_addr  = cpu.cpu_addr;
        ram_we    = cpu.cpu_we && w_cin;
        ram_wdata = cpu.cpu_wdata;
      end else if (w_vin) begin
        ram_addr = ADDR_WIDTH'(32'(vid_y) * 32'(WIDTH) + 32'(vid_x));
      end
    end
  end

  always_comb begin
    cpu.cpu_ack   = (r_state == S_ACK) && !reset;
    cpu.cpu_rdata = (cpu.cpu_ack && r_rd_ok) ? ram_rdata : 8'h00;
    dbg_state     = r_state;
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vld   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_black <= 1'b0;
      r_vpend <= '0;
      r_rd_ok <= 1'b0;
      vid_r   <= 8'h00;
      vid_g   <= 8'h00;
      vid_b   <= 8'h00;
    end else begin
      r_vpend <= w_slot;
      if (w_slot) begin
        r_vld   <= 1'b1;
        r_x     <= vid_x;
        r_y     <= vid_y;
        r_black <= !w_vin;
      end
      // ram_rdata here belongs to the previous cycle's video address.
      if (r_vpend[PIX_LATENCY-2])
        {vid_r, vid_g, vid_b} <= rgb332(r_black ? 8'h00 : ram_rdata);
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_ACK;
            r_rd_ok <= !cpu.cpu_we && w_cin;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rd_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, per-cycle video model with an
// expected-pixel queue, and a CPU expected-read-data queue.
module tb_vram_arbiter;
  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AW = 17;

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } vexp_t;

  logic          clock25 = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   vid_x = 12'd3;
  logic [11:0]   vid_y = 12'd2;
  logic [7:0]    vid_r, vid_g, vid_b;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'h00;
  logic          dbg_state;

  vram_cpu_if #(.ADDR_WIDTH(AW)) cpu_bus ();

  vram_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .PIX_LATENCY(2)) dut (
    .clock25   (clock25),
    .reset     (reset),
    .vid_x     (vid_x),
    .vid_y     (vid_y),
    .vid_r     (vid_r),
    .vid_g     (vid_g),
    .vid_b     (vid_b),
    .cpu       (cpu_bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #20 clock25 = ~clock25;

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model and reference contents ----------------
  logic [7:0] mem [0:(1<<AW)-1];
  bit         mem_wr [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  bit         ref_wr [0:(1<<AW)-1];

  function automatic logic [7:0] pat(input int a);
    if (a == 643) return 8'hE0;
    return 8'(a * 29 + 7);
  endfunction

  always @(posedge clock25) begin
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      mem_wr[ram_addr] <= 1'b1;
    end
    ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
  end

  function automatic logic [7:0] ref_rd(input int a);
    return ref_wr[a] ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [23:0] rgb332(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3],
            p[1:0], p[1:0], p[1:0], p[1:0]};
  endfunction

  function automatic bit pix_in(input logic [11:0] x, input logic [11:0] y);
    return (int'(x) < W) && (int'(y) < H);
  endfunction

  function automatic logic [AW-1:0] vaddr(input logic [11:0] x, input logic [11:0] y);
    return pix_in(x, y) ? AW'(int'(y) * W + int'(x)) : '0;
  endfunction

  function automatic logic [23:0] exp_pix(input logic [11:0] x, input logic [11:0] y);
    return pix_in(x, y) ? rgb332(ref_rd(int'(y) * W + int'(x))) : 24'h0;
  endfunction

  // ---------------- checking ----------------
  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  vexp_t      vq[$];
  logic [7:0] exp_q[$];
  bit          mon_en = 0;
  int          cyc = 0;
  int          last_ack = -1;
  int          we_cnt = 0;
  logic [23:0] exp_vid = 24'h0;
  bit          rst_pend = 0;
  bit          prev_slot = 0;
  bit          m_vld = 0;
  bit          m_slot;
  logic [11:0] m_x = '0;
  logic [11:0] m_y = '0;
  vexp_t       m_e;
  logic [AW-1:0] t_addr = '0;
  logic [7:0]    t_wd = '0;

  always @(negedge clock25) begin
    if (mon_en) begin
      cyc++;
      if (rst_pend) begin
        exp_vid  = 24'h0;
        rst_pend = 0;
      end
      while (vq.size() > 0 && vq[0].due <= cyc) begin
        m_e     = vq.pop_front();
        exp_vid = m_e.rgb;
      end
      check_eq("vid_rgb", {8'h00, vid_r, vid_g, vid_b}, {8'h00, exp_vid});
      if (reset) begin
        check_eq("rst_ack", 32'(cpu_bus.cpu_ack), 0);
        check_eq("rst_rdata", 32'(cpu_bus.cpu_rdata), 0);
        check_eq("rst_we", 32'(ram_we), 0);
        check_eq("rst_addr", 32'(ram_addr), 0);
        m_vld     = 0;
        prev_slot = 0;
        rst_pend  = 1;
        vq.delete();
        exp_q.delete();
      end else begin
        m_slot = !m_vld || (vid_x != m_x) || (vid_y != m_y);
        if (m_slot) begin
          check_eq("vid_addr", 32'(ram_addr), 32'(vaddr(vid_x, vid_y)));
          check_eq("vid_slot_we", 32'(ram_we), 0);
          vq.push_back('{due: cyc + 2, rgb: exp_pix(vid_x, vid_y)});
          m_vld = 1;
          m_x   = vid_x;
          m_y   = vid_y;
        end
        if (ram_we) begin
          we_cnt++;
          check_eq("we_addr", 32'(ram_addr), 32'(t_addr));
          check_eq("we_data", 32'(ram_wdata), 32'(t_wd));
          check_eq("we_in_range", 32'(int'(t_addr) < W * H), 1);
        end
        if (cpu_bus.cpu_ack) begin
          last_ack = cyc;
          check_eq("issue_in_video_slot", 32'(prev_slot), 0);
          check_eq("ack_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0)
            check_eq("cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'(exp_q.pop_front()));
        end
        prev_slot = m_slot;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [7:0] wd, output logic [7:0] rd);
    bit got_ack;
    bit in_rng;
    in_rng  = int'(addr) < W * H;
    got_ack = 0;
    rd      = 8'h00;
    @(posedge clock25);
    #1;
    t_addr = addr;
    t_wd   = wd;
    we_cnt = 0;
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_wdata = wd;
    exp_q.push_back((we || !in_rng) ? 8'h00 : ref_rd(int'(addr)));
    for (int n = 0; n < 1000 && !got_ack; n++) begin
      @(negedge clock25);
      if (cpu_bus.cpu_ack === 1'b1) got_ack = 1;
    end
    if (!got_ack) check_eq("ack_timeout", 0, 1);
    rd = cpu_bus.cpu_rdata;
    check_eq("we_pulses", 32'(we_cnt), (we && in_rng) ? 1 : 0);
    if (we && in_rng) begin
      ref_mem[addr] = wd;
      ref_wr[addr]  = 1'b1;
    end
    @(posedge clock25);
    #1;
    cpu_bus.cpu_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rd;
  int         hold_c;

  initial begin
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = 8'h00;
    repeat (3) @(posedge clock25);
    mon_en = 1;
    @(posedge clock25);
    #1 reset = 1'b0;

    // reset release with (3,2) held: address 643, red pixel two cycles on
    @(negedge clock25);
    check_eq("first_addr", 32'(ram_addr), 643);
    @(negedge clock25);
    @(negedge clock25);
    check_eq("pix643_rgb", {8'h00, vid_r, vid_g, vid_b}, 32'h00FF0000);

    // write then read back with x/y held
    cpu_txn(1'b1, 17'd100, 8'h1C, rd);
    check_eq("wr_rdata", 32'(rd), 0);
    cpu_txn(1'b0, 17'd100, 8'h00, rd);
    check_eq("rd100", 32'(rd), 32'h1C);

    // pixel every 2 cycles with a CPU read stream
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clock25);
          #1;
          vid_x = 12'(i);
          vid_y = 12'd7;
          @(posedge clock25);
        end
      end
      begin
        logic [7:0] rd2;
        for (int k = 0; k < 20; k++)
          cpu_txn(1'b0, AW'($urandom_range(0, W * H - 1)), 8'h00, rd2);
      end
    join

    // pixel every cycle for 640 cycles: CPU must wait for the hold
    fork
      begin
        for (int i = 0; i < 640; i++) begin
          @(posedge clock25);
          #1;
          vid_x = 12'(i);
          vid_y = 12'd5;
        end
        @(posedge clock25);
        #1;
        hold_c = cyc + 1;
      end
      begin
        logic [7:0] rd3;
        cpu_txn(1'b0, 17'd1234, 8'h00, rd3);
      end
    join
    check_eq("starve_no_early_ack", 32'(last_ack > hold_c), 1);
    check_eq("starve_ack_latency", 32'(last_ack <= hold_c + 2), 1);

    // out-of-range CPU accesses
    @(posedge clock25);
    #1;
    vid_x = 12'd3;
    vid_y = 12'd2;
    cpu_txn(1'b1, 17'd76800, 8'hFF, rd);
    check_eq("oor_wr_rdata", 32'(rd), 0);
    cpu_txn(1'b0, 17'd76800, 8'h00, rd);
    check_eq("oor_rd_rdata", 32'(rd), 0);

    // out-of-range pixel is black
    @(posedge clock25);
    #1;
    vid_x = 12'd320;
    vid_y = 12'd0;
    repeat (3) @(negedge clock25);
    check_eq("oor_pixel", {8'h00, vid_r, vid_g, vid_b}, 0);

    // reset while in ACK: no pulse, outputs cleared
    @(posedge clock25);
    #1;
    vid_x = 12'd3;
    vid_y = 12'd2;
    @(posedge clock25);
    #1;
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = 17'd5;
    @(posedge clock25);
    #1;
    reset = 1'b1;
    cpu_bus.cpu_req = 1'b0;
    @(negedge clock25);
    check_eq("ack_in_reset", 32'(cpu_bus.cpu_ack), 0);
    @(posedge clock25);
    #1 reset = 1'b0;
    @(negedge clock25);
    check_eq("vid_after_reset", {8'h00, vid_r, vid_g, vid_b}, 0);
    check_eq("slot_after_reset", 32'(ram_addr), 643);

    repeat (4) @(posedge clock25);
    cpu_txn(1'b0, 17'd643, 8'h00, rd);
    check_eq("rd643_after_reset", 32'(rd), 32'hE0);

    repeat (3) @(posedge clock25);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read framebuffer RAM between two users: the HDMI scan-out pixel fetch and a CPU-side requester.
- Sits between the HDMI timing block (supplies pixel x/y, consumes r/g/b) and the framebuffer RAM.
- Scan-out has strict priority. The CPU uses the free RAM cycles through a req/ack handshake.
- Pixels are stored as RGB332 and expanded to 8:8:8 for HDMI.

Parameters:
- WIDTH, 320, framebuffer width in pixels.
- HEIGHT, 240, framebuffer height in pixels.
- ADDR_WIDTH, 17, RAM word-address width; must satisfy 2^ADDR_WIDTH >= WIDTH*HEIGHT.
- PIX_LATENCY, 2, fixed x/y-to-rgb latency in cycles (documentation constant, not tunable). The HDMI timing block pairs with it as CYCLE_DELAY = 2.

Ports:
- clock25  in  1  pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- vid_x  in  12  scan-out pixel column
- vid_y  in  12  scan-out pixel row
- vid_r  out  8  expanded red
- vid_g  out  8  expanded green
- vid_b  out  8  expanded blue
- cpu_req  in  1  CPU access request; held with addr/we/wdata stable until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  8  RGB332 write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data; valid when cpu_ack = 1
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, one cycle after ram_addr

Behaviour:
- Clocking and reset:
  - One clock: clock25.
  - reset is synchronous and active-high.
- Reset values:
  - vid_r/g/b = 0; cpu_ack = 0; cpu_rdata = 0.
  - ram_we = 0; ram_addr = 0; ram_wdata = 0.
  - CPU FSM = IDLE.
  - last-coordinate valid flag = 0.
- Video slot:
  - Cycle n is a video slot when the flag is clear, or when (vid_x, vid_y) differs from the last registered coordinate.
  - In a video slot: set the flag; register the coordinate; drive ram_addr = vid_y*WIDTH + vid_x; ram_we = 0.
- Video out-of-range:
  - If vid_x >= WIDTH or vid_y >= HEIGHT, the slot is still consumed and ram_addr = 0.
  - The pixel is tagged black.
- Video pipeline:
  - Cycle n+1: capture ram_rdata (or force 0 if tagged black).
  - Cycle n+2: vid_* registered with the expansion below, giving a total latency of 2.
  - vid_* holds its value between video slots.
- RGB332 expansion of p:
  - r = {p[7:5], p[7:5], p[7:6]}
  - g = {p[4:2], p[4:2], p[4:3]}
  - b = {p[1:0], p[1:0], p[1:0], p[1:0]}
- Address arithmetic:
  - Full-width product; truncate to ADDR_WIDTH only after the range check.
- CPU FSM, IDLE:
  - If cpu_req = 1 and the cycle is not a video slot, issue: ram_addr = cpu_addr, ram_we = cpu_we and in-range, ram_wdata = cpu_wdata. Go to ACK.
  - Otherwise stay in IDLE; RAM outputs carry the video address with ram_we = 0.
- CPU FSM, ACK:
  - cpu_ack = 1; cpu_rdata = ram_rdata for in-range reads, 0 otherwise (writes: rdata = 0). Return to IDLE.
  - No new CPU issue is allowed in ACK, so at most one CPU access per 2 cycles.
  - A video slot may still occur in this cycle.
- CPU handshake rules:
  - If cpu_req is still high in the cycle after ack, it is a new transaction.
  - Dropping cpu_req while waiting in IDLE cancels the request with no side effects.
- CPU out-of-range:
  - cpu_addr >= WIDTH*HEIGHT: write suppressed (ram_we = 0), read returns 0, ack still given.
- Simultaneous events:
  - Video slot and cpu_req in the same cycle: video wins; the CPU waits in IDLE and issues in the first non-video cycle.
- Starvation:
  - With a new pixel every cycle, the CPU is served only in blanking, when x/y hold still.
  - No starvation timeout.
- Reset mid-operation:
  - A pending ACK is dropped (no cpu_ack pulse); vid_* go to 0.
  - The first cycle after reset is always a video slot.
- ram_we is 1 only in an IDLE issue cycle for an in-range CPU write.

Test Plan:
- Reset, then hold x=3, y=2 with RAM[643]=0xE0 -> ram_addr=643 in the first cycle; vid_r=0xFF, vid_g=0, vid_b=0 two cycles later.
- Write with x/y held: cpu_req, we=1, addr=100, wdata=0x1C -> ram_we for 1 cycle, cpu_ack 1 cycle later. A following read of addr 100 returns cpu_rdata=0x1C with ack.
- x advancing every 2 cycles (XDIV=2) plus a continuous CPU read stream -> CPU accesses occur only in non-video cycles. Every pixel has latency exactly 2; no video slot is ever missed.
- x advancing every cycle for 640 cycles with cpu_req high -> no ack during the run; ack within 2 cycles once x/y hold.
- cpu_addr=76800 write 0xFF, then read -> ram_we never asserted; ack given; cpu_rdata=0x00.
- vid_x=320, y=0 -> vid_* = 0. Assert reset during ACK -> no ack pulse; outputs 0 the next cycle.
